// File: rtl/secure_reset_seq_pkg.sv
// Shared types and default timing for the post-reset secure sequencer.
package secure_seq_pkg;

  typedef enum logic [1:0] {CAPTURE, COUNT, STROBE, DONE} seq_state_t;

  localparam int STATUS_CYC_D = 9;
  localparam int STROBE_CYC_D = 14;
  localparam int STROBE_LEN_D = 1;
  localparam int DATA_W_D     = 32;
  localparam int CNT_W_D      = 8;

endpackage

// File: rtl/secure_reset_seq_if.sv
// Control/status bundle between the sequencer and its neighbours.
// master drives the requests (secure_in/clr_n/restart); slave is the sequencer.
interface secure_reset_seq_if #(
  parameter int DATA_W = 32
);
  logic              secure_in;
  logic              clr_n;
  logic              restart;
  logic [DATA_W-1:0] data;
  logic              secure_out;
  logic              status;
  logic              strobe;
  logic              done;

  modport master (
    output secure_in, clr_n, restart,
    input  data, secure_out, status, strobe, done
  );

  modport slave (
    input  secure_in, clr_n, restart,
    output data, secure_out, status, strobe, done
  );
endinterface

// File: rtl/secure_reset_seq_data_hold.sv
// Data register with synchronous clear/restore. A clear parks the current word
// in hold; release restores it unless secure mode is latched. Loads arriving
// while cleared land in hold so they surface on release.
module secure_data_hold #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst1,
  input  logic              clr_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_val,
  input  logic              secure,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] hold;
  logic              clr_q;   // clr_n from previous edge, for edge detect

  // clear / hold / restore / sequence load
  always_ff @(posedge clk or negedge rst1) begin
    if (!rst1) begin
      data  <= '0;
      hold  <= '0;
      clr_q <= 1'b1;
    end else begin
      clr_q <= clr_n;
      if (!clr_n) begin
        data <= '0;
        if (load)       hold <= load_val;
        else if (clr_q) hold <= data;
      end else if (load) begin
        // a fresh sequence load is newer than anything parked in hold
        data <= load_val;
      end else if (!clr_q) begin
        data <= secure ? '0 : hold;
      end
    end
  end

endmodule

// File: rtl/secure_reset_seq.sv
// Post-reset sequencer: latches secure mode one edge after rst1 release, then
// drops status, pulses strobe and raises done at fixed edge counts. Data gets
// FILL_VAL at the status edge (non-secure) or the strobe edge (secure).
// Optional build macro: SECURE_LOCK_EN makes secure_out sticky across restarts.
module secure_reset_seq
  import secure_seq_pkg::*;
#(
  parameter int              DATA_W     = DATA_W_D,
  parameter logic [DATA_W-1:0] FILL_VAL = DATA_W'('hFF),
  parameter int              STATUS_CYC = STATUS_CYC_D,
  parameter int              STROBE_CYC = STROBE_CYC_D,
  parameter int              STROBE_LEN = STROBE_LEN_D,
  parameter int              CNT_W      = CNT_W_D
) (
  input  logic                clk,
  input  logic                rst1,
  secure_reset_seq_if.slave   bus
);

  localparam logic [CNT_W-1:0] STATUS_AT = CNT_W'(STATUS_CYC);
  localparam logic [CNT_W-1:0] STROBE_AT = CNT_W'(STROBE_CYC);
  localparam logic [CNT_W-1:0] END_AT    = CNT_W'(STROBE_CYC + STROBE_LEN);

  if (STROBE_CYC <= STATUS_CYC) begin : g_bad_order
    $error("secure_reset_seq: STROBE_CYC must be greater than STATUS_CYC");
  end
  if (STROBE_LEN < 1) begin : g_bad_len
    $error("secure_reset_seq: STROBE_LEN must be at least 1");
  end
  if (STATUS_CYC < 2) begin : g_bad_status
    // secure mode is only latched at edge 1, so the status edge must follow it
    $error("secure_reset_seq: STATUS_CYC must be at least 2");
  end
  if (longint'(STROBE_CYC + STROBE_LEN) >= (longint'(1) << CNT_W)) begin : g_bad_cnt
    $error("secure_reset_seq: CNT_W too narrow for STROBE_CYC+STROBE_LEN");
  end

  seq_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             sec_q, sec_nx;
  logic             status_q, status_nx;
  logic             strobe_q, strobe_nx;
  logic             done_q, done_nx;
  logic             load;

  // state and sequence registers
  always_ff @(posedge clk or negedge rst1) begin
    if (!rst1) begin
      state    <= CAPTURE;
      cnt      <= '0;
      sec_q    <= 1'b0;
      status_q <= 1'b1;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      sec_q    <= sec_nx;
      status_q <= status_nx;
      strobe_q <= strobe_nx;
      done_q   <= done_nx;
    end
  end

  // next-state, counter and load decode; events key off the value cnt is about to take
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    sec_nx    = sec_q;
    status_nx = status_q;
    strobe_nx = strobe_q;
    done_nx   = done_q;
    load      = 1'b0;
    if (state != DONE) cnt_nx = cnt + 1'b1;
    case (state)
      CAPTURE: begin
`ifdef SECURE_LOCK_EN
        sec_nx = sec_q | bus.secure_in;
`else
        sec_nx = bus.secure_in;
`endif
        state_nx = COUNT;
      end
      COUNT: begin
        if (cnt_nx == STATUS_AT) begin
          status_nx = 1'b0;
          load      = !sec_q;
        end
        if (cnt_nx == STROBE_AT) begin
          strobe_nx = 1'b1;
          state_nx  = STROBE;
          load      = sec_q;
        end
      end
      STROBE: begin
        if (cnt_nx == END_AT) begin
          strobe_nx = 1'b0;
          done_nx   = 1'b1;
          state_nx  = DONE;
        end
      end
      DONE: begin
        if (bus.restart) begin
          cnt_nx    = '0;
          status_nx = 1'b1;
          done_nx   = 1'b0;
          state_nx  = CAPTURE;
        end
      end
      default: state_nx = CAPTURE;
    endcase
  end

  secure_data_hold #(.DATA_W(DATA_W)) u_hold (
    .clk      (clk),
    .rst1     (rst1),
    .clr_n    (bus.clr_n),
    .load     (load),
    .load_val (FILL_VAL),
    .secure   (sec_q),
    .data     (bus.data)
  );

  assign bus.secure_out = sec_q;
  assign bus.status     = status_q;
  assign bus.strobe     = strobe_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_secure_reset_seq.sv
// Bench for secure_reset_seq: directed scenarios plus a randomized run, all
// compared against an edge-count model of the sequence.
module tb_secure_reset_seq;
  import secure_seq_pkg::*;

  localparam int DW  = 32;
  localparam int SC  = STATUS_CYC_D;
  localparam int SB  = STROBE_CYC_D;
  localparam int SL  = 1;
  localparam int CW  = 8;
  localparam int ENDN = SB + SL;
  localparam logic [DW-1:0] FILL = 32'hFF;
`ifdef SECURE_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rst1 = 1'b0;
  int   nchk = 0;
  int   nerr = 0;

  secure_reset_seq_if #(.DATA_W(DW)) bus ();

  secure_reset_seq #(
    .DATA_W(DW), .FILL_VAL(FILL), .STATUS_CYC(SC),
    .STROBE_CYC(SB), .STROBE_LEN(SL), .CNT_W(CW)
  ) dut (
    .clk  (clk),
    .rst1 (rst1),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // model: n = edges since release/restart, saturating at ENDN
  int          n;
  bit          msec;
  logic [DW-1:0] md, mhold;
  bit          mclr_low;

  task automatic model_reset();
    n = 0; msec = 0; md = '0; mhold = '0; mclr_low = 0;
  endtask

  task automatic model_step(input bit si, input bit cn, input bit rs);
    bit load;
    bit sec_old;
    load    = 0;
    sec_old = msec;
    if (n == ENDN) begin
      if (rs) n = 0;
    end else begin
      n++;
      if (n == 1) msec = LOCK ? (msec | si) : si;
      if ((n == SC && !msec) || (n == SB && msec)) load = 1;
    end
    if (!cn) begin
      if (load)          mhold = FILL;
      else if (!mclr_low) mhold = md;
      md = '0;
    end else if (load) begin
      md = FILL;
    end else if (mclr_low) begin
      md = sec_old ? '0 : mhold;
    end
    mclr_low = !cn;
  endtask

  function automatic logic [DW+3:0] expv();
    return {md, msec, (n < SC), (n >= SB && n < ENDN), (n == ENDN)};
  endfunction

  function automatic logic [DW+3:0] obs();
    return {bus.data, bus.secure_out, bus.status, bus.strobe, bus.done};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst1) model_step(bus.secure_in, bus.clr_n, bus.restart);
    #1;
  endtask

  task automatic do_reset(input bit si);
    rst1 = 1'b0;
    bus.secure_in = si; bus.clr_n = 1'b1; bus.restart = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst1 = 1'b1;
  endtask

  task automatic test_reset();
    logic [DW+3:0] rv;
    rv = {{DW{1'b0}}, 1'b0, 1'b1, 1'b0, 1'b0};
    rst1 = 1'b0;
    bus.secure_in = 1'b1; bus.clr_n = 1'b1; bus.restart = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    nchk++;
    if (obs() !== rv) begin
      nerr++; $display("FAIL reset_values: got %h expected %h", obs(), rv);
    end
  endtask

  task automatic test_normal();
    do_reset(1'b0);
    for (int e = 1; e <= ENDN + 2; e++) begin
      tick();
      nchk++;
      if (obs() !== expv()) begin
        nerr++; $display("FAIL normal_e%0d: got %h expected %h", e, obs(), expv());
      end
      if (e == SC - 1) begin
        nchk++;
        if (bus.status !== 1'b1 || bus.data !== '0) begin
          nerr++; $display("FAIL normal_pre_status: status=%b data=%h expected 1/0", bus.status, bus.data);
        end
      end
      if (e == SC) begin
        nchk++;
        if (bus.status !== 1'b0 || bus.data !== 32'hFF) begin
          nerr++; $display("FAIL normal_status_edge: status=%b data=%h expected 0/ff", bus.status, bus.data);
        end
      end
      if (e == SB) begin
        nchk++;
        if (bus.strobe !== 1'b1 || bus.done !== 1'b0) begin
          nerr++; $display("FAIL normal_strobe_edge: strobe=%b done=%b expected 1/0", bus.strobe, bus.done);
        end
      end
      if (e == ENDN) begin
        nchk++;
        if (bus.strobe !== 1'b0 || bus.done !== 1'b1) begin
          nerr++; $display("FAIL normal_done_edge: strobe=%b done=%b expected 0/1", bus.strobe, bus.done);
        end
      end
    end
  endtask

  task automatic test_secure();
    do_reset(1'b1);
    for (int e = 1; e <= ENDN; e++) begin
      tick();
      bus.secure_in = 1'($urandom);   // live input must not matter after capture
      nchk++;
      if (obs() !== expv()) begin
        nerr++; $display("FAIL secure_e%0d: got %h expected %h", e, obs(), expv());
      end
      if (e == 1) begin
        nchk++;
        if (bus.secure_out !== 1'b1) begin
          nerr++; $display("FAIL secure_latch: got %b expected 1", bus.secure_out);
        end
      end
      if (e == SB - 1) begin
        nchk++;
        if (bus.data !== '0) begin
          nerr++; $display("FAIL secure_data_early: got %h expected 0", bus.data);
        end
      end
      if (e == SB) begin
        nchk++;
        if (bus.data !== 32'hFF) begin
          nerr++; $display("FAIL secure_data_load: got %h expected ff", bus.data);
        end
      end
    end
  endtask

  task automatic test_clear_done();
    for (int s = 0; s < 2; s++) begin
      do_reset(1'(s));
      repeat (ENDN + 1) tick();
      bus.clr_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tick();
        nchk++;
        if (bus.data !== '0 || obs() !== expv()) begin
          nerr++; $display("FAIL clear_low_s%0d: got %h expected data 0 (%h)", s, obs(), expv());
        end
      end
      bus.clr_n = 1'b1;
      tick();
      nchk++;
      if (bus.data !== (s ? 32'h0 : 32'hFF) || obs() !== expv()) begin
        nerr++; $display("FAIL clear_restore_s%0d: got %h expected %h", s, obs(), expv());
      end
    end
  endtask

  task automatic test_clear_load();
    do_reset(1'b0);
    repeat (SC - 2) tick();
    bus.clr_n = 1'b0;
    repeat (3) tick();
    nchk++;
    if (bus.data !== '0 || dut.u_hold.hold !== 32'hFF || bus.status !== 1'b0) begin
      nerr++; $display("FAIL clear_load_hold: data=%h hold=%h status=%b expected 0/ff/0",
                       bus.data, dut.u_hold.hold, bus.status);
    end
    bus.clr_n = 1'b1;
    tick();
    nchk++;
    if (bus.data !== 32'hFF || obs() !== expv()) begin
      nerr++; $display("FAIL clear_load_restore: got %h expected %h", obs(), expv());
    end
  endtask

  task automatic test_midreset();
    logic [DW+3:0] rv;
    rv = {{DW{1'b0}}, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset(1'b0);
    repeat (12) tick();
    #2 rst1 = 1'b0;
    #1;
    nchk++;
    if (obs() !== rv) begin
      nerr++; $display("FAIL midreset_values: got %h expected %h", obs(), rv);
    end
    model_reset();
    @(negedge clk);
    rst1 = 1'b1;
    for (int e = 1; e <= ENDN; e++) begin
      tick();
      nchk++;
      if (obs() !== expv()) begin
        nerr++; $display("FAIL midreset_e%0d: got %h expected %h", e, obs(), expv());
      end
      if (e == SB) begin
        nchk++;
        if (bus.strobe !== 1'b1) begin
          nerr++; $display("FAIL midreset_strobe: got %b expected 1", bus.strobe);
        end
      end
    end
  endtask

  task automatic test_restart();
    // restart in COUNT is ignored; then restart from DONE with secure_in flipped
    do_reset(1'b0);
    repeat (5) tick();
    bus.restart = 1'b1; tick(); bus.restart = 1'b0;
    repeat (ENDN - 6) tick();
    nchk++;
    if (bus.done !== 1'b1 || obs() !== expv()) begin
      nerr++; $display("FAIL restart_ignored: got %h expected %h", obs(), expv());
    end
    bus.secure_in = 1'b1;
    bus.restart = 1'b1; tick(); bus.restart = 1'b0;
    nchk++;
    if (bus.status !== 1'b1 || bus.done !== 1'b0 || bus.data !== 32'hFF) begin
      nerr++; $display("FAIL restart_accept: status=%b done=%b data=%h expected 1/0/ff",
                       bus.status, bus.done, bus.data);
    end
    tick();
    nchk++;
    if (bus.secure_out !== 1'b1) begin
      nerr++; $display("FAIL restart_resample: got %b expected 1", bus.secure_out);
    end
    repeat (ENDN) tick();
    bus.secure_in = 1'b0;
    bus.restart = 1'b1; tick(); bus.restart = 1'b0;
    tick();
    nchk++;
    if (bus.secure_out !== LOCK) begin
      nerr++; $display("FAIL restart_lock: got %b expected %b", bus.secure_out, LOCK);
    end
    repeat (ENDN) tick();
    nchk++;
    if (obs() !== expv()) begin
      nerr++; $display("FAIL restart_rerun: got %h expected %h", obs(), expv());
    end
  endtask

  task automatic test_random();
    do_reset(1'($urandom));
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset(1'($urandom));
      bus.secure_in = 1'($urandom);
      bus.clr_n     = ($urandom_range(0, 4) != 0);
      bus.restart   = ($urandom_range(0, 5) == 0);
      tick();
      nchk++;
      if (obs() !== expv()) begin
        nerr++; $display("FAIL random_i%0d: got %h expected %h", i, obs(), expv());
      end
    end
    bus.restart = 1'b0; bus.clr_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_secure();
    test_clear_done();
    test_clear_load();
    test_midreset();
    test_restart();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
